// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: owns the PC, drives the target-table index,
// applies absolute/relative jumps and runs the IDLE/RUN/HALT start/done handshake.
module pc_sequencer #(
    parameter int D  = 10,
    parameter int A  = 4,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [D-1:0]  StartAddr,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          AbsJump,
    input  logic          RelJump,
    input  logic [A-1:0]  LutIdx,
    output logic [A-1:0]  LutAddr,
    input  logic [D-1:0]  LutTarget,
    output logic [D-1:0]  ProgCtr,
    output logic          FetchValid,
    output logic          Done,
    output logic [CW-1:0] InstCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          fetch_valid_q, fetch_valid_d;
    logic          done_q, done_d;

    assign LutAddr = LutIdx;

    // Retired count sticks at all-ones rather than wrapping.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    pc_d  = StartAddr;
                    cnt_d = '0;
                end else if (Halt) begin
                    cnt_d   = cnt_inc;
                    state_d = HALT;
                end else if (Stall) begin
                    pc_d  = pc_q;
                end else if (AbsJump) begin
                    pc_d  = LutTarget;
                    cnt_d = cnt_inc;
                end else if (RelJump) begin
                    // Two's-complement add in D bits makes negative offsets work for free.
                    pc_d  = pc_q + LutTarget;
                    cnt_d = cnt_inc;
                end else begin
                    pc_d  = pc_q + D'(1);
                    cnt_d = cnt_inc;
                end
            end
            HALT: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fetch_valid_d = (state_d == RUN);
        done_d        = (state_d == HALT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            done_q        <= done_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign FetchValid = fetch_valid_q;
    assign Done       = done_q;
    assign InstCount  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: sequential fetch, jumps, wrap, stall,
// halt/restart, counter saturation and asynchronous reset.
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  StartAddr;
    logic        Stall;
    logic        Halt;
    logic        AbsJump;
    logic        RelJump;
    logic [3:0]  LutIdx;
    logic [3:0]  LutAddr;
    logic [9:0]  LutTarget;
    logic [9:0]  ProgCtr;
    logic        FetchValid;
    logic        Done;
    logic [15:0] InstCount;

    int n_compared;
    int n_mismatched;

    pc_sequencer #(.D(10), .A(4), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .AbsJump(AbsJump), .RelJump(RelJump),
        .LutIdx(LutIdx), .LutAddr(LutAddr), .LutTarget(LutTarget),
        .ProgCtr(ProgCtr), .FetchValid(FetchValid), .Done(Done),
        .InstCount(InstCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Target table answers whatever index the DUT drives out.
    function automatic logic [9:0] lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 10'd0;
            4'd1:    return 10'd11;
            4'd2:    return 10'd41;
            4'd3:    return 10'd99;
            4'd4:    return 10'd72;
            4'd5:    return 10'h3FF;
            4'd6:    return 10'h014;
            default: return 10'd0;
        endcase
    endfunction

    assign LutTarget = lut(LutAddr);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_requests();
        Start = 0; Stall = 0; Halt = 0; AbsJump = 0; RelJump = 0; LutIdx = 4'd0;
    endtask

    task automatic start_at(input logic [9:0] addr);
        Start = 1; StartAddr = addr;
        tick();
        Start = 0;
    endtask

    task automatic test_reset();
        clear_requests();
        StartAddr = 10'd0;
        Reset = 1;
        #1 Reset = 0;
        #2;
        n_compared++; if (ProgCtr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %0d want 0", ProgCtr); end
        n_compared++; if (FetchValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_fv: got %b want 0", FetchValid); end
        n_compared++; if (Done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b want 0", Done); end
        n_compared++; if (InstCount !== 16'd0) begin n_mismatched++; $display("[TB] FAIL reset_cnt: got %0d want 0", InstCount); end
        @(negedge Clk);
        Reset = 1;
        AbsJump = 1; LutIdx = 4'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_compared++; if (ProgCtr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL idle_pc: got %0d want 0", ProgCtr); end
            n_compared++; if (FetchValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_fv: got %b want 0", FetchValid); end
        end
        clear_requests();
    endtask

    task automatic test_sequential();
        start_at(10'd0);
        n_compared++; if (FetchValid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL seq_fv: got %b want 1", FetchValid); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_compared++; if (ProgCtr !== 10'(i)) begin n_mismatched++; $display("[TB] FAIL seq_pc: got %0d want %0d", ProgCtr, i); end
            n_compared++; if (InstCount !== 16'(i)) begin n_mismatched++; $display("[TB] FAIL seq_cnt: got %0d want %0d", InstCount, i); end
        end
    endtask

    task automatic test_abs_jump();
        AbsJump = 1; LutIdx = 4'd2;
        #1;
        n_compared++; if (LutAddr !== 4'd2) begin n_mismatched++; $display("[TB] FAIL lut_addr: got %0d want 2", LutAddr); end
        tick();
        n_compared++; if (ProgCtr !== 10'd41) begin n_mismatched++; $display("[TB] FAIL abs_pc: got %0d want 41", ProgCtr); end
        n_compared++; if (InstCount !== 16'd5) begin n_mismatched++; $display("[TB] FAIL abs_cnt: got %0d want 5", InstCount); end
        clear_requests();
    endtask

    task automatic test_rel_jump();
        start_at(10'd4);
        RelJump = 1; LutIdx = 4'd5;
        tick();
        n_compared++; if (ProgCtr !== 10'd3) begin n_mismatched++; $display("[TB] FAIL rel_neg_pc: got %0d want 3", ProgCtr); end
        LutIdx = 4'd6;
        tick();
        n_compared++; if (ProgCtr !== 10'd23) begin n_mismatched++; $display("[TB] FAIL rel_pos_pc: got %0d want 23", ProgCtr); end
        n_compared++; if (InstCount !== 16'd2) begin n_mismatched++; $display("[TB] FAIL rel_cnt: got %0d want 2", InstCount); end
        clear_requests();
        start_at(10'd1023);
        tick();
        n_compared++; if (ProgCtr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL wrap_up_pc: got %0d want 0", ProgCtr); end
        RelJump = 1; LutIdx = 4'd5;
        tick();
        n_compared++; if (ProgCtr !== 10'd1023) begin n_mismatched++; $display("[TB] FAIL wrap_down_pc: got %0d want 1023", ProgCtr); end
        AbsJump = 1; LutIdx = 4'd3;
        tick();
        n_compared++; if (ProgCtr !== 10'd99) begin n_mismatched++; $display("[TB] FAIL abs_over_rel_pc: got %0d want 99", ProgCtr); end
        clear_requests();
    endtask

    task automatic test_stall();
        start_at(10'd6);
        tick();
        Stall = 1; AbsJump = 1; LutIdx = 4'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++; if (ProgCtr !== 10'd7) begin n_mismatched++; $display("[TB] FAIL stall_pc: got %0d want 7", ProgCtr); end
            n_compared++; if (InstCount !== 16'd1) begin n_mismatched++; $display("[TB] FAIL stall_cnt: got %0d want 1", InstCount); end
        end
        clear_requests();
        tick();
        n_compared++; if (ProgCtr !== 10'd8) begin n_mismatched++; $display("[TB] FAIL unstall_pc: got %0d want 8", ProgCtr); end
        n_compared++; if (InstCount !== 16'd2) begin n_mismatched++; $display("[TB] FAIL unstall_cnt: got %0d want 2", InstCount); end
    endtask

    task automatic test_halt();
        start_at(10'd19);
        tick();
        Halt = 1;
        tick();
        clear_requests();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_compared++; if (Done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL halt_done: got %b want 1", Done); end
            n_compared++; if (FetchValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL halt_fv: got %b want 0", FetchValid); end
            n_compared++; if (ProgCtr !== 10'd20) begin n_mismatched++; $display("[TB] FAIL halt_pc: got %0d want 20", ProgCtr); end
            n_compared++; if (InstCount !== 16'd2) begin n_mismatched++; $display("[TB] FAIL halt_cnt: got %0d want 2", InstCount); end
        end
        start_at(10'd5);
        n_compared++; if (ProgCtr !== 10'd5) begin n_mismatched++; $display("[TB] FAIL restart_pc: got %0d want 5", ProgCtr); end
        n_compared++; if (Done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL restart_done: got %b want 0", Done); end
        n_compared++; if (InstCount !== 16'd0) begin n_mismatched++; $display("[TB] FAIL restart_cnt: got %0d want 0", InstCount); end
        n_compared++; if (FetchValid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL restart_fv: got %b want 1", FetchValid); end
    endtask

    task automatic test_saturation();
        start_at(10'd0);
        repeat (65535) tick();
        n_compared++; if (InstCount !== 16'hFFFF) begin n_mismatched++; $display("[TB] FAIL sat_cnt: got %0d want 65535", InstCount); end
        n_compared++; if (ProgCtr !== 10'd1023) begin n_mismatched++; $display("[TB] FAIL sat_pc: got %0d want 1023", ProgCtr); end
        tick();
        n_compared++; if (InstCount !== 16'hFFFF) begin n_mismatched++; $display("[TB] FAIL sat_hold_cnt: got %0d want 65535", InstCount); end
        n_compared++; if (ProgCtr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL sat_wrap_pc: got %0d want 0", ProgCtr); end
    endtask

    task automatic test_reset_midrun();
        start_at(10'd30);
        repeat (3) tick();
        n_compared++; if (ProgCtr !== 10'd33) begin n_mismatched++; $display("[TB] FAIL pre_abort_pc: got %0d want 33", ProgCtr); end
        #3 Reset = 0;
        #1;
        n_compared++; if (ProgCtr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL abort_pc: got %0d want 0", ProgCtr); end
        n_compared++; if (FetchValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_fv: got %b want 0", FetchValid); end
        n_compared++; if (Done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_done: got %b want 0", Done); end
        n_compared++; if (InstCount !== 16'd0) begin n_mismatched++; $display("[TB] FAIL abort_cnt: got %0d want 0", InstCount); end
        @(negedge Clk);
        Reset = 1;
        repeat (2) tick();
        n_compared++; if (FetchValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_abort_fv: got %b want 0", FetchValid); end
        n_compared++; if (ProgCtr !== 10'd0) begin n_mismatched++; $display("[TB] FAIL post_abort_pc: got %0d want 0", ProgCtr); end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_sequential();
        test_abs_jump();
        test_rel_jump();
        test_stall();
        test_halt();
        test_saturation();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
